mgt_rx_framer: RTL and testbench

MGT_RX_FRAMER -- requirements
Module: mgt_rx_framer

---
 rtl/mgt_rx_pkg.sv | 15 +
 rtl/mgt_rx_framer_if.sv | 22 ++
 rtl/mgt_rx_lane_check.sv | 25 ++
 rtl/mgt_rx_framer.sv | 181 ++++++++++++++++++
 tb/tb_mgt_rx_framer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mgt_rx_pkg.sv
// Shared definitions for the MGT receive framer: framing state encoding and comma default.
package mgt_rx_pkg;

    localparam int STATE_W    = 2;
    localparam int RETRY_CNT_W = 16;
    localparam logic [7:0] COMMA_CHAR_DEFAULT = 8'hBC;

    typedef enum logic [STATE_W-1:0] {
        RESET_WAIT = 2'd0,
        HUNT       = 2'd1,
        SYNCED     = 2'd2,
        RETRY      = 2'd3
    } rxState_t;

endpackage

// File: rtl/mgt_rx_framer_if.sv
// Transceiver word stream into the framer and framed EVR character stream out of it.
interface mgt_rx_framer_if #(
    parameter int BYTES = 2
);
    logic [8*BYTES-1:0] rxData;
    logic [BYTES-1:0]   rxCharIsK;
    logic [BYTES-1:0]   rxCharIsComma;
    logic [BYTES-1:0]   rxCharNotInTable;
    logic [8*BYTES-1:0] evrChars;
    logic [BYTES-1:0]   evrCharIsK;
    logic [BYTES-1:0]   evrCharIsComma;

    modport master (
        output rxData, rxCharIsK, rxCharIsComma, rxCharNotInTable,
        input  evrChars, evrCharIsK, evrCharIsComma
    );

    modport slave (
        input  rxData, rxCharIsK, rxCharIsComma, rxCharNotInTable,
        output evrChars, evrCharIsK, evrCharIsComma
    );
endinterface

// File: rtl/mgt_rx_lane_check.sv
// Combinational word classifier: clean / good lane-0 comma / error, plus per-fault flags.
module mgt_rx_lane_check
    import mgt_rx_pkg::*;
#(
    parameter int         BYTES      = 2,
    parameter logic [7:0] COMMA_CHAR = COMMA_CHAR_DEFAULT
) (
    input  logic [7:0]       lane0Data,
    input  logic [BYTES-1:0] rxCharIsK,
    input  logic [BYTES-1:0] rxCharNotInTable,
    output logic             clean,
    output logic             goodComma,
    output logic             errorWord,
    output logic             badChar,
    output logic             badK
);
    // Framing is lane-0 only, so a K character in any higher lane marks a misaligned word.
    always_comb begin
        badChar   = |rxCharNotInTable;
        badK      = |rxCharIsK[BYTES-1:1];
        clean     = !badChar && !badK;
        errorWord = !clean;
        goodComma = clean && rxCharIsK[0] && (lane0Data == COMMA_CHAR);
    end
endmodule

// File: rtl/mgt_rx_framer.sv
// Receive framer: hunts for lane-0 commas, holds sync against an error budget, retries the GT.
// Optional fault statistics counters are built only with MGT_RX_FRAMER_STATS_EN defined.
module mgt_rx_framer
    import mgt_rx_pkg::*;
#(
    parameter int         BYTES               = 2,
    parameter logic [7:0] COMMA_CHAR          = COMMA_CHAR_DEFAULT,
    parameter int         COMMAS_NEEDED       = 30,
    parameter int         LOSS_ERRORS         = 8,
    parameter int         HUNT_TIMEOUT        = 65535,
    parameter int         RESET_PULSE         = 16,
    parameter int         FAULT_COUNTER_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mgt_rx_framer_if.slave                 rxIf,
    input  logic                           gtResetDone,
    input  logic                           autoRetry,
    input  logic                           clearStats,
    output logic                           rxSynchronized,
    output logic                           gtResetReq,
    output logic [STATE_W-1:0]             state,
    output logic [RETRY_CNT_W-1:0]         retryCount,
    output logic [FAULT_COUNTER_WIDTH-1:0] badCharCount,
    output logic [FAULT_COUNTER_WIDTH-1:0] badKcount
);
    localparam int CW = $clog2(COMMAS_NEEDED + 1);
    localparam int HW = $clog2(HUNT_TIMEOUT + 1);
    localparam int LW = $clog2(LOSS_ERRORS + 1);
    localparam int PW = $clog2(RESET_PULSE + 1);
    localparam logic [CW-1:0] COMMA_LOAD = CW'(COMMAS_NEEDED);
    localparam logic [CW-1:0] COMMA_LAST = CW'(1);
    localparam logic [HW-1:0] HUNT_LIMIT = HW'(HUNT_TIMEOUT);
    localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_ERRORS - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE - 1);

    function automatic logic [RETRY_CNT_W-1:0] satIncRetry(input logic [RETRY_CNT_W-1:0] v);
        return (&v) ? v : v + RETRY_CNT_W'(1);
    endfunction

    rxState_t      stateQ, stateNext;
    logic [CW-1:0] commaCnt, commaNext;
    logic [HW-1:0] huntTimer, huntNext;
    logic [LW-1:0] budget, budgetNext;
    logic [PW-1:0] pulseCnt, pulseNext;
    logic          retryInc;
    logic          clean, goodComma, errorWord, badChar, badK;

    mgt_rx_lane_check #(
        .BYTES      (BYTES),
        .COMMA_CHAR (COMMA_CHAR)
    ) u_laneCheck (
        .lane0Data        (rxIf.rxData[7:0]),
        .rxCharIsK        (rxIf.rxCharIsK),
        .rxCharNotInTable (rxIf.rxCharNotInTable),
        .clean            (clean),
        .goodComma        (goodComma),
        .errorWord        (errorWord),
        .badChar          (badChar),
        .badK             (badK)
    );

    always_comb begin
        stateNext  = stateQ;
        commaNext  = commaCnt;
        huntNext   = huntTimer;
        budgetNext = budget;
        pulseNext  = pulseCnt;
        retryInc   = 1'b0;
        unique case (stateQ)
            RESET_WAIT: begin
                if (gtResetDone) begin
                    stateNext = HUNT;
                    commaNext = COMMA_LOAD;
                    huntNext  = '0;
                end
            end
            HUNT: begin
                if (huntTimer != HUNT_LIMIT) huntNext = huntTimer + HW'(1);
                if (errorWord)      commaNext = COMMA_LOAD;
                else if (goodComma) commaNext = commaCnt - COMMA_LAST;
                if (!gtResetDone) begin
                    stateNext = RESET_WAIT;
                end else if (goodComma && commaCnt == COMMA_LAST) begin
                    stateNext  = SYNCED;
                    commaNext  = COMMA_LOAD;
                    budgetNext = '0;
                end else if (autoRetry && huntTimer == HUNT_LIMIT) begin
                    stateNext = RETRY;
                    pulseNext = '0;
                    retryInc  = 1'b1;
                end
            end
            SYNCED: begin
                // Leaky bucket: errors fill it, clean commas drain it down to empty.
                if (errorWord)                       budgetNext = budget + LW'(1);
                else if (goodComma && budget != '0)  budgetNext = budget - LW'(1);
                if (!gtResetDone) begin
                    stateNext = RESET_WAIT;
                end else if (errorWord && budget == LOSS_LAST) begin
                    stateNext  = HUNT;
                    budgetNext = '0;
                    commaNext  = COMMA_LOAD;
                    huntNext   = '0;
                end
            end
            RETRY: begin
                if (pulseCnt == PULSE_LAST) stateNext = RESET_WAIT;
                else                        pulseNext = pulseCnt + PW'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ         <= RESET_WAIT;
            commaCnt       <= COMMA_LOAD;
            huntTimer      <= '0;
            budget         <= '0;
            pulseCnt       <= '0;
            rxSynchronized <= 1'b0;
            gtResetReq     <= 1'b0;
            retryCount     <= '0;
        end else begin
            stateQ         <= stateNext;
            commaCnt       <= commaNext;
            huntTimer      <= huntNext;
            budget         <= budgetNext;
            pulseCnt       <= pulseNext;
            rxSynchronized <= (stateNext == SYNCED);
            gtResetReq     <= (stateNext == RETRY);
            if (clearStats)    retryCount <= '0;
            else if (retryInc) retryCount <= satIncRetry(retryCount);
        end
    end

    assign state = stateQ;

    // Output stage: one-cycle registered copy of clean words while synchronized.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxIf.evrChars       <= '0;
            rxIf.evrCharIsK     <= '0;
            rxIf.evrCharIsComma <= '0;
        end else if (stateQ == SYNCED && clean) begin
            rxIf.evrChars       <= rxIf.rxData;
            rxIf.evrCharIsK     <= rxIf.rxCharIsK;
            rxIf.evrCharIsComma <= rxIf.rxCharIsComma;
        end else begin
            rxIf.evrChars       <= '0;
            rxIf.evrCharIsK     <= '0;
            rxIf.evrCharIsComma <= '0;
        end
    end

`ifdef MGT_RX_FRAMER_STATS_EN
    function automatic logic [FAULT_COUNTER_WIDTH-1:0] satIncFault(
        input logic [FAULT_COUNTER_WIDTH-1:0] v);
        return (&v) ? v : v + FAULT_COUNTER_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            badCharCount <= '0;
            badKcount    <= '0;
        end else if (clearStats) begin
            badCharCount <= '0;
            badKcount    <= '0;
        end else if (stateQ == SYNCED) begin
            if (badChar) badCharCount <= satIncFault(badCharCount);
            if (badK)    badKcount    <= satIncFault(badKcount);
        end
    end
`else
    logic unusedStatFlags;
    assign unusedStatFlags = badChar ^ badK;
    assign badCharCount    = '0;
    assign badKcount       = '0;
`endif

endmodule

// File: tb/tb_mgt_rx_framer.sv
// Scoreboard bench for mgt_rx_framer: a 2-byte instance (short hunt timeout) and a 4-byte instance.
`timescale 1ns/1ps
module tb_mgt_rx_framer;
    import mgt_rx_pkg::*;

`ifdef MGT_RX_FRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        gtDoneA, autoRetryA, clearA, syncA, reqA;
    logic [1:0]  stateA;
    logic [15:0] retryA;
    logic [9:0]  badCharA, badKA;
    logic        gtDoneB, autoRetryB, clearB, syncB, reqB;
    logic [1:0]  stateB;
    logic [15:0] retryB;
    logic [9:0]  badCharB, badKB;

    mgt_rx_framer_if #(.BYTES(2)) ifA ();
    mgt_rx_framer_if #(.BYTES(4)) ifB ();

    mgt_rx_framer #(.BYTES(2), .HUNT_TIMEOUT(100)) dutA (
        .clk(clk), .rst_n(rst_n), .rxIf(ifA),
        .gtResetDone(gtDoneA), .autoRetry(autoRetryA), .clearStats(clearA),
        .rxSynchronized(syncA), .gtResetReq(reqA), .state(stateA),
        .retryCount(retryA), .badCharCount(badCharA), .badKcount(badKA)
    );

    mgt_rx_framer #(.BYTES(4)) dutB (
        .clk(clk), .rst_n(rst_n), .rxIf(ifB),
        .gtResetDone(gtDoneB), .autoRetry(autoRetryB), .clearStats(clearB),
        .rxSynchronized(syncB), .gtResetReq(reqB), .state(stateB),
        .retryCount(retryB), .badCharCount(badCharB), .badKcount(badKB)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] chars;
        logic [1:0]  k;
        logic [1:0]  comma;
        logic        sync;
        logic [1:0]  st;
    } expA_t;

    expA_t    sbq[$];
    rxState_t expPrev = HUNT;

    // Drive one word into instance A at a falling edge and queue the response it must produce.
    task automatic sendA(input logic [15:0] d, input logic [1:0] k, input logic [1:0] nit,
                         input rxState_t expSt, input logic clr);
        expA_t      e;
        logic [1:0] cm;
        logic       pass;
        cm   = (k[0] && d[7:0] == 8'hBC) ? 2'b01 : 2'b00;
        ifA.rxData = d; ifA.rxCharIsK = k; ifA.rxCharIsComma = cm; ifA.rxCharNotInTable = nit;
        clearA = clr;
        pass    = (expPrev == SYNCED) && (nit == 2'b00) && (k[1] == 1'b0);
        e.chars = pass ? d : 16'h0;
        e.k     = pass ? k : 2'b00;
        e.comma = pass ? cm : 2'b00;
        e.sync  = (expSt == SYNCED);
        e.st    = expSt;
        sbq.push_back(e);
        expPrev = expSt;
        @(negedge clk);
        clearA = 1'b0;
    endtask

    task automatic sendB(input logic [31:0] d, input logic [3:0] k,
                         input rxState_t expSt, input logic [31:0] expEvr);
        ifB.rxData = d; ifB.rxCharIsK = k; ifB.rxCharIsComma = k; ifB.rxCharNotInTable = 4'b0;
        @(negedge clk);
        chk("B.state", stateB, expSt);
        chk("B.evrChars", ifB.evrChars, expEvr);
    endtask

    // Monitor: every word captured by instance A is checked just after the capturing edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            expA_t e;
            e = sbq.pop_front();
            chk("A.evrChars", ifA.evrChars, e.chars);
            chk("A.evrCharIsK", ifA.evrCharIsK, e.k);
            chk("A.evrCharIsComma", ifA.evrCharIsComma, e.comma);
            chk("A.rxSynchronized", syncA, e.sync);
            chk("A.state", stateA, e.st);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst_n = 1'b1;
        ifA.rxData = '0; ifA.rxCharIsK = '0; ifA.rxCharIsComma = '0; ifA.rxCharNotInTable = '0;
        ifB.rxData = '0; ifB.rxCharIsK = '0; ifB.rxCharIsComma = '0; ifB.rxCharNotInTable = '0;
        gtDoneA = 0; autoRetryA = 0; clearA = 0;
        gtDoneB = 0; autoRetryB = 0; clearB = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.state", stateA, RESET_WAIT);
        chk("reset.rxSynchronized", syncA, 1'b0);
        chk("reset.gtResetReq", reqA, 1'b0);
        chk("reset.retryCount", retryA, 16'h0);
        chk("reset.evrChars", ifA.evrChars, 16'h0);
        chk("reset.badCharCount", badCharA, 10'h0);
        chk("reset.B.state", stateB, RESET_WAIT);
        rst_n = 1'b1;
        @(negedge clk);
        chk("waitDone.state", stateA, RESET_WAIT);
        gtDoneA = 1'b1;
        @(negedge clk);
        chk("enterHunt.state", stateA, HUNT);

        // Hunt restarts its comma count after an error word.
        expPrev = HUNT;
        repeat (29) sendA(16'h00BC, 2'b01, 2'b00, HUNT, 1'b0);
        sendA(16'h00BC, 2'b01, 2'b01, HUNT, 1'b0);
        repeat (29) sendA(16'h00BC, 2'b01, 2'b00, HUNT, 1'b0);
        sendA(16'h00BC, 2'b01, 2'b00, SYNCED, 1'b0);
        sendA(16'hA55A, 2'b00, 2'b00, SYNCED, 1'b0);
        sendA(16'h3C7E, 2'b00, 2'b00, SYNCED, 1'b0);
        sendA(16'h00BC, 2'b01, 2'b00, SYNCED, 1'b0);

        // Error budget: 7 errors drained by commas keeps sync; 8 in a row drops it.
        for (int r = 0; r < 4; r++) begin
            repeat (7) sendA(16'h0000, 2'b00, 2'b01, SYNCED, 1'b0);
            repeat (7) sendA(16'h00BC, 2'b01, 2'b00, SYNCED, 1'b0);
        end
        repeat (7) sendA(16'h0000, 2'b00, 2'b01, SYNCED, 1'b0);
        sendA(16'h0000, 2'b00, 2'b01, HUNT, 1'b0);
        sendA(16'h1234, 2'b00, 2'b00, HUNT, 1'b0);
        chk("badCharCount.accum", badCharA, STATS ? 10'd36 : 10'd0);

        repeat (29) sendA(16'h00BC, 2'b01, 2'b00, HUNT, 1'b0);
        sendA(16'h00BC, 2'b01, 2'b00, SYNCED, 1'b0);
        sendA(16'h0000, 2'b00, 2'b01, SYNCED, 1'b1);
        chk("clearStats.badCharCount", badCharA, 10'd0);

        gtDoneA = 1'b0;
        @(negedge clk);
        chk("gtDoneLow.state", stateA, RESET_WAIT);
        chk("gtDoneLow.rxSynchronized", syncA, 1'b0);
        ifA.rxData = '0; ifA.rxCharIsK = '0; ifA.rxCharIsComma = '0; ifA.rxCharNotInTable = '0;
        autoRetryA = 1'b1;
        gtDoneA = 1'b1;
        @(negedge clk);
        chk("reHunt.state", stateA, HUNT);

        cnt = 0;
        while (stateA == HUNT && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt < 100 || cnt > 101) begin
            errors++;
            $display("FAIL huntTimeout cycles=%0d required=100..101", cnt);
        end
        chk("retry.state", stateA, RETRY);
        chk("retry.retryCount", retryA, 16'd1);
        gtDoneA = 1'b0;
        cnt = 0;
        while (reqA && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("retry.pulseWidth", cnt, 16);
        chk("retryDone.state", stateA, RESET_WAIT);
        chk("retryDone.retryCount", retryA, 16'd1);
        gtDoneA = 1'b1;
        autoRetryA = 1'b0;
        @(negedge clk);
        chk("retryRehunt.state", stateA, HUNT);
        clearA = 1'b1;
        @(negedge clk);
        clearA = 1'b0;
        chk("clearStats.retryCount", retryA, 16'd0);

        expPrev = HUNT;
        repeat (29) sendA(16'h00BC, 2'b01, 2'b00, HUNT, 1'b0);
        sendA(16'h00BC, 2'b01, 2'b00, SYNCED, 1'b0);
        sendA(16'hBEEF, 2'b00, 2'b00, SYNCED, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("asyncReset.state", stateA, RESET_WAIT);
        chk("asyncReset.rxSynchronized", syncA, 1'b0);
        chk("asyncReset.evrChars", ifA.evrChars, 16'h0);
        chk("asyncReset.gtResetReq", reqA, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four-byte instance: a comma with K in lane 2 is an error word.
        gtDoneB = 1'b1;
        @(negedge clk);
        chk("B.enterHunt", stateB, HUNT);
        repeat (40) sendB(32'h00BC0000, 4'b0100, HUNT, 32'h0);
        chk("B.neverSynced", syncB, 1'b0);
        repeat (29) sendB(32'h000000BC, 4'b0001, HUNT, 32'h0);
        sendB(32'h000000BC, 4'b0001, SYNCED, 32'h0);
        sendB(32'h11223344, 4'b0000, SYNCED, 32'h11223344);
        repeat (3) sendB(32'h00BC0000, 4'b0100, SYNCED, 32'h0);
        chk("B.badKcount", badKB, STATS ? 10'd3 : 10'd0);
        chk("B.badCharCount", badCharB, 10'd0);
        chk("B.rxSynchronized", syncB, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
